bp_mmio_word_splitter: RTL and testbench
========================================

# bp_mmio_word_splitter

Sits between the BlackParrot I/O command/response port and the BP-to-manycore MMIO bridge, which carries only one 32-bit manycore word per command. Accepts one uncached BedRock mem command at a time, splits commands wider than 4 bytes into naturally ordered 4-byte beats, and issues them downstream. It then collects the in-order per-beat responses and merges them into a single BedRock response carrying the original header. Commands of 4 bytes or less pass through as a single beat.

## Interface
- bp_params_p, e_bp_default_cfg: BP configuration; supplies paddr_width_p, cce_block_width_p and cce_mem_msg_width_lp.
- mc_data_width_p, 32: width of one manycore beat in bits; beat size is 4 bytes.
- Derived: max_beats_lp = cce_block_width_p/mc_data_width_p; beat counter width is `$clog2(max_beats_lp+1)`.

Ports (clock and reset first):
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- io_cmd_i  in  cce_mem_msg_width_lp  upstream command (bp_bedrock_cce_mem_msg_s).
- io_cmd_v_i  in  1  upstream command valid.
- io_cmd_ready_o  out  1  ready; a transfer occurs when v & ready are both high.
- io_resp_o  out  cce_mem_msg_width_lp  merged response to upstream.
- io_resp_v_o  out  1  merged response valid.
- io_resp_yumi_i  in  1  upstream consumes the response.
- io_cmd_o  out  cce_mem_msg_width_lp  per-beat command to the MMIO bridge.
- io_cmd_v_o  out  1  beat command valid.
- io_cmd_ready_i  in  1  bridge ready; a transfer occurs when v & ready are both high.
- io_resp_i  in  cce_mem_msg_width_lp  per-beat response from the bridge.
- io_resp_v_i  in  1  beat response valid.
- io_resp_yumi_o  out  1  splitter consumes the beat response.

## Operation
- **FSM states:** e_idle, e_busy, e_resp.
- **e_idle**
  - io_cmd_ready_o is 1.
  - On handshake, latch the header and data.
  - Compute beats = 1 if size ≤ 4 bytes, else size_bytes/4. For 512-bit blocks, size 8 gives 2 beats and size 64 gives 16.
  - Clear send_cnt and recv_cnt, then go to e_busy.
- **Beat command formation**
  - Header equals the latched header with two changes:
    - Single-beat: addr and size are unchanged.
    - Multi-beat: size = e_bedrock_msg_size_4 and addr = (addr with low $clog2(size_bytes) bits forced to 0) + 4·send_cnt. Misaligned low bits are ignored.
  - msg_type and payload are unchanged.
  - Data: [31:0] = latched data[32·send_cnt +: 32]; upper bits are zero.
- **e_busy: send side**
  - io_cmd_v_o = (send_cnt < beats), with no dependence on io_cmd_ready_i.
  - send_cnt increments on each handshake.
- **e_busy: receive side**
  - io_resp_yumi_o = io_resp_v_i & (recv_cnt < beats).
  - Responses are assumed in order, because the bridge returns in order.
  - On yumi, write io_resp_i.data[31:0] into the merge register at [32·recv_cnt +: 32], then increment recv_cnt.
  - Sending and receiving overlap: a response may arrive before the last beat has been sent.
  - When recv_cnt reaches beats, go to e_resp.
- **e_resp**
  - io_resp_v_o = 1.
  - io_resp_o header = latched original header (original addr and size).
  - io_resp_o data = merge register; bits above 32·beats are zero.
  - Write responses carry the merge data unchanged.
  - On io_resp_yumi_i, go to e_idle.
- **Outside e_busy:** io_cmd_v_o = 0 and io_resp_yumi_o = 0. A stray io_resp_v_i is left pending and is not consumed.

## Timing
- **Reset values:**
  - State is e_idle; counters and merge register are 0.
  - While reset_i is high: io_cmd_ready_o = 0, io_cmd_v_o = 0, io_resp_v_o = 0, io_resp_yumi_o = 0.
  - io_cmd_ready_o = 1 on the first cycle after reset deasserts.
  - Reset in any state abandons the transaction; no response is issued.
- **Latency:**
  - Upstream accept in cycle N → first beat valid in N+1.
  - One beat can be issued per cycle.
  - Last beat response accepted in cycle M → io_resp_v_o in M+1.
  - Response yumi in cycle R → io_cmd_ready_o in R+1.
  - Minimum round trip, 1-beat with zero-latency bridge: accept N, beat N+1, response N+1, merged response N+2.
- **Throughput:** one upstream command in flight; io_cmd_ready_o = 0 in e_busy and e_resp.
- **Simultaneous events:** a send handshake and a receive handshake in the same cycle both take effect.
- **Stalls:** io_cmd_o is stable while io_cmd_v_o & !io_cmd_ready_i. io_resp_o is stable while io_resp_v_o & !io_resp_yumi_i.
- **Counter wrap:** none; counters saturate at beats and are cleared on accept.

## Test plan
- **4-byte uc_rd at 0x0010_0004:** 1 beat with addr 0x0010_0004, size_4; bridge returns 0xDEADBEEF → io_resp_o.data[31:0] = 0xDEADBEEF, upper bits 0, header = original.
- **8-byte uc_wr at 0x0010_0008, data 0x1122334455667788:** beats (0x0010_0008, 0x55667788), then (0x0010_000C, 0x11223344), both size_4; after 2 responses, a single response with the size_8 header.
- **8-byte uc_rd at misaligned 0x0010_000C:** beats at 0x0010_0008 and 0x0010_000C; responses 0xAAAA0000 and 0x0000BBBB → data 0x0000BBBB_AAAA0000.
- **64-byte rd with io_cmd_ready_i toggling every other cycle and responses interleaved with sends:** 16 beats at base+0 through base+60; merge is correct, with no duplicate or dropped beats.
- **Upstream io_resp_yumi_i held low 5 cycles:** io_resp_o is stable and io_cmd_ready_o stays 0; stray io_resp_v_i in e_idle gets no yumi.
- **Reset asserted mid-transfer (after beat 1 of 2):** next cycle all valid outputs are 0; after release, a fresh 4-byte command completes normally.

Source files
------------

// File: rtl/bp_mmio_word_splitter.sv
// bp_mmio_word_splitter: splits one uncached BedRock command into 4-byte MMIO beats and merges the beat responses
//   clk_i, reset_i                  : clock, synchronous active-high reset
//   io_cmd_i/_v_i/_ready_o          : upstream command (valid/ready)
//   io_resp_o/_v_o, io_resp_yumi_i  : merged response to upstream (valid/yumi)
//   io_cmd_o/_v_o, io_cmd_ready_i   : per-beat command to the MMIO bridge (valid/ready)
//   io_resp_i/_v_i, io_resp_yumi_o  : per-beat response from the bridge (valid/yumi)
// Message layout (MSB first): data, payload, size, addr, msg_type.
module bp_mmio_word_splitter #(
   parameter int paddr_width_p        = 40,
   parameter int cce_block_width_p    = 512,
   parameter int payload_width_p      = 20,
   parameter int mc_data_width_p      = 32,
   parameter int cce_mem_msg_width_lp = cce_block_width_p + payload_width_p + 3 + paddr_width_p + 4
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
   input  logic                            io_cmd_v_i,
   output logic                            io_cmd_ready_o,
   output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
   output logic                            io_resp_v_o,
   input  logic                            io_resp_yumi_i,
   output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
   output logic                            io_cmd_v_o,
   input  logic                            io_cmd_ready_i,
   input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
   input  logic                            io_resp_v_i,
   output logic                            io_resp_yumi_o
);
   localparam int max_beats_lp = cce_block_width_p / mc_data_width_p;
   localparam int max_lg_lp    = $clog2(max_beats_lp);
   localparam int cnt_w_lp     = $clog2(max_beats_lp + 1);
   localparam logic [1:0] e_idle = 2'd0;
   localparam logic [1:0] e_busy = 2'd1;
   localparam logic [1:0] e_resp = 2'd2;
   localparam logic [2:0] e_bedrock_msg_size_4 = 3'd2;

   typedef struct packed {
      logic [cce_block_width_p-1:0] data;
      logic [payload_width_p-1:0]   payload;
      logic [2:0]                   size;
      logic [paddr_width_p-1:0]     addr;
      logic [3:0]                   msg_type;
   } msg_s;

   msg_s                         cmd_in, resp_in, beat_cmd, resp_out, cmd_q, cmd_d;
   logic [1:0]                   state_q, state_d;
   logic [cnt_w_lp-1:0]          beats_q, beats_d, send_cnt_q, send_cnt_d, recv_cnt_q, recv_cnt_d, in_beats;
   logic [cce_block_width_p-1:0] merge_q, merge_d;
   logic [paddr_width_p-1:0]     base_addr;
   logic                         accept, send_hs, unused_resp;

   always_comb begin
      cmd_in  = msg_s'(io_cmd_i);
      resp_in = msg_s'(io_resp_i);
      unused_resp = ^{resp_in.data[cce_block_width_p-1:mc_data_width_p], resp_in.payload, resp_in.size, resp_in.addr, resp_in.msg_type};
      // Sizes above a full block are clamped so the beat count never exceeds the merge register.
      in_beats = (cmd_in.size <= e_bedrock_msg_size_4) ? cnt_w_lp'(1)
               : (int'(cmd_in.size) - 2 >= max_lg_lp) ? cnt_w_lp'(max_beats_lp)
               : cnt_w_lp'(1) << (cmd_in.size - 3'd2);
      io_cmd_ready_o = ~reset_i & (state_q == e_idle);
      io_cmd_v_o     = ~reset_i & (state_q == e_busy) & (send_cnt_q < beats_q);
      io_resp_yumi_o = ~reset_i & (state_q == e_busy) & io_resp_v_i & (recv_cnt_q < beats_q);
      io_resp_v_o    = ~reset_i & (state_q == e_resp);
      accept  = io_cmd_ready_o & io_cmd_v_i;
      send_hs = io_cmd_v_o & io_cmd_ready_i;
      // Multi-beat addresses start from the naturally aligned base; misaligned low bits are dropped.
      base_addr = cmd_q.addr & ~((paddr_width_p'(1) << cmd_q.size) - paddr_width_p'(1));
      beat_cmd = cmd_q;
      beat_cmd.data = '0;
      beat_cmd.data[mc_data_width_p-1:0] = mc_data_width_p'(cmd_q.data >> (send_cnt_q * mc_data_width_p));
      beat_cmd.size = (cmd_q.size > e_bedrock_msg_size_4) ? e_bedrock_msg_size_4 : cmd_q.size;
      beat_cmd.addr = (cmd_q.size > e_bedrock_msg_size_4) ? base_addr + (paddr_width_p'(send_cnt_q) << 2) : cmd_q.addr;
      io_cmd_o = beat_cmd;
      resp_out = cmd_q;
      resp_out.data = merge_q;
      io_resp_o = resp_out;
      cmd_d      = accept ? cmd_in : cmd_q;
      beats_d    = accept ? in_beats : beats_q;
      send_cnt_d = accept ? '0 : send_cnt_q + cnt_w_lp'(send_hs);
      recv_cnt_d = accept ? '0 : recv_cnt_q + cnt_w_lp'(io_resp_yumi_o);
      merge_d = accept ? '0
              : io_resp_yumi_o ? (merge_q & ~(cce_block_width_p'({mc_data_width_p{1'b1}}) << (recv_cnt_q * mc_data_width_p)))
                                 | (cce_block_width_p'(resp_in.data[mc_data_width_p-1:0]) << (recv_cnt_q * mc_data_width_p))
              : merge_q;
      state_d = (state_q == e_idle) ? (accept ? e_busy : e_idle)
              : (state_q == e_busy) ? ((recv_cnt_d == beats_q) ? e_resp : e_busy)
              : (io_resp_yumi_i ? e_idle : e_resp);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= e_idle;
         cmd_q      <= '0;
         beats_q    <= '0;
         send_cnt_q <= '0;
         recv_cnt_q <= '0;
         merge_q    <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         beats_q    <= beats_d;
         send_cnt_q <= send_cnt_d;
         recv_cnt_q <= recv_cnt_d;
         merge_q    <= merge_d;
      end
   end
endmodule

// File: tb/tb_bp_mmio_word_splitter.sv
// tb_bp_mmio_word_splitter: scoreboard bench for bp_mmio_word_splitter with a small in-order bridge model
module tb_bp_mmio_word_splitter;
   localparam int PA = 40, BW = 512, PL = 20, MW = BW + PL + 3 + PA + 4;
   localparam logic [3:0] UC_RD = 4'd2, UC_WR = 4'd3;
   localparam logic [PL-1:0] PLD = 20'hABCDE;

   typedef struct packed {
      logic [BW-1:0] data;
      logic [PL-1:0] payload;
      logic [2:0]    size;
      logic [PA-1:0] addr;
      logic [3:0]    msg_type;
   } msg_t;

   logic clk = 0, reset_i = 1;
   msg_t io_cmd_i, io_resp_o, io_cmd_o, io_resp_i;
   logic io_cmd_v_i, io_cmd_ready_o, io_resp_v_o, io_resp_yumi_i;
   logic io_cmd_v_o, io_cmd_ready_i, io_resp_v_i, io_resp_yumi_o;

   int tests = 0, fails = 0, beats_seen = 0, inflight = 0, cyc = 0, rdy_limit = 1 << 30;
   bit tog_rdy = 0, resp_en = 1, stray = 0, auto_yumi = 1;
   msg_t exp_cmd_q[$], exp_resp_q[$];
   logic [31:0] rdata_q[$];
   logic [BW-1:0] cd, rd;

   bp_mmio_word_splitter #(.paddr_width_p(PA), .cce_block_width_p(BW), .payload_width_p(PL), .mc_data_width_p(32)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
      .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
      .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i),
      .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o)
   );

   always #5 clk = ~clk;

   function automatic msg_t mk(input logic [3:0] t, input logic [PA-1:0] a, input logic [2:0] s, input logic [BW-1:0] d);
      msg_t m;
      m.msg_type = t; m.addr = a; m.size = s; m.payload = PLD; m.data = d;
      return m;
   endfunction

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bridge, upstream consumer and scoreboard monitor: drive at negedge+1, observe handshakes at negedge+3.
   always @(negedge clk) begin
      logic [31:0] w;
      #1;
      cyc++;
      io_cmd_ready_i = (beats_seen < rdy_limit) && (!tog_rdy || cyc[0]);
      io_resp_v_i = stray || (resp_en && inflight > 0);
      w = (rdata_q.size() > 0) ? rdata_q[0] : 32'h0;
      io_resp_i = mk(4'd0, '0, 3'd2, BW'(w));
      io_resp_yumi_i = auto_yumi && io_resp_v_o;
      #2;
      if (!reset_i) begin
         if (io_cmd_v_o && io_cmd_ready_i) begin
            beats_seen++;
            inflight++;
            if (exp_cmd_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL beat_unexpected: got %h expected no beat", io_cmd_o);
            end else chk("beat", io_cmd_o, exp_cmd_q.pop_front());
         end
         if (io_resp_v_i && io_resp_yumi_o) begin
            if (inflight == 0) begin
               tests++; fails++;
               $display("FAIL stray_yumi: got yumi 1 expected 0 with no beat in flight");
            end else begin
               inflight--;
               if (rdata_q.size() > 0) void'(rdata_q.pop_front());
            end
         end
         if (io_resp_v_o && io_resp_yumi_i) begin
            if (exp_resp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL resp_unexpected: got %h expected no response", io_resp_o);
            end else chk("merged_resp", io_resp_o, exp_resp_q.pop_front());
         end
      end
   end

   task automatic send(input msg_t m);
      @(negedge clk);
      io_cmd_i = m;
      io_cmd_v_i = 1;
      for (int i = 0; i < 100; i++) begin
         #3;
         if (io_cmd_ready_o) break;
         if (i == 99) begin
            tests++; fails++;
            $display("FAIL cmd_accept_timeout: got ready 0 expected 1 within 100 cycles");
         end
         @(negedge clk);
      end
      @(negedge clk);
      io_cmd_v_i = 0;
   endtask

   task automatic wait_done(input string name);
      int i;
      for (i = 0; i < 1000; i++) begin
         @(negedge clk); #4;
         if (exp_cmd_q.size() == 0 && exp_resp_q.size() == 0) break;
      end
      if (i == 1000) begin
         tests++; fails++;
         $display("FAIL %s_timeout: %0d beats and %0d responses outstanding, expected 0", name, exp_cmd_q.size(), exp_resp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int i;
      msg_t m;
      io_cmd_v_i = 0; io_cmd_i = '0; io_cmd_ready_i = 0; io_resp_v_i = 0; io_resp_i = '0; io_resp_yumi_i = 0;
      reset_i = 1;
      repeat (2) @(negedge clk);
      #3;
      chk("rst_cmd_ready", io_cmd_ready_o, 0);
      chk("rst_cmd_v", io_cmd_v_o, 0);
      chk("rst_resp_v", io_resp_v_o, 0);
      chk("rst_resp_yumi", io_resp_yumi_o, 0);
      @(negedge clk);
      reset_i = 0;
      #3;
      chk("ready_after_rst", io_cmd_ready_o, 1);

      // 4-byte uncached read, single beat passes through
      rdata_q.push_back(32'hDEADBEEF);
      exp_cmd_q.push_back(mk(UC_RD, 40'h0010_0004, 3'd2, '0));
      exp_resp_q.push_back(mk(UC_RD, 40'h0010_0004, 3'd2, BW'(32'hDEADBEEF)));
      send(mk(UC_RD, 40'h0010_0004, 3'd2, '0));
      #3;
      chk("t1_beat_valid_next_cycle", io_cmd_v_o, 1);
      wait_done("t1");

      // 8-byte uncached write, two beats
      rdata_q.push_back(32'h0BAD0001);
      rdata_q.push_back(32'h0BAD0002);
      exp_cmd_q.push_back(mk(UC_WR, 40'h0010_0008, 3'd2, BW'(32'h55667788)));
      exp_cmd_q.push_back(mk(UC_WR, 40'h0010_000C, 3'd2, BW'(32'h11223344)));
      exp_resp_q.push_back(mk(UC_WR, 40'h0010_0008, 3'd3, BW'(64'h0BAD0002_0BAD0001)));
      send(mk(UC_WR, 40'h0010_0008, 3'd3, BW'(64'h1122334455667788)));
      wait_done("t2");

      // 8-byte read at a misaligned address
      rdata_q.push_back(32'hAAAA0000);
      rdata_q.push_back(32'h0000BBBB);
      exp_cmd_q.push_back(mk(UC_RD, 40'h0010_0008, 3'd2, '0));
      exp_cmd_q.push_back(mk(UC_RD, 40'h0010_000C, 3'd2, '0));
      exp_resp_q.push_back(mk(UC_RD, 40'h0010_000C, 3'd3, BW'(64'h0000BBBB_AAAA0000)));
      send(mk(UC_RD, 40'h0010_000C, 3'd3, '0));
      wait_done("t3");

      // 64-byte read, bridge ready toggling, responses overlapping sends
      tog_rdy = 1;
      cd = '0; rd = '0;
      for (int k = 0; k < 16; k++) begin
         cd[32*k +: 32] = 32'hC0DE0000 + k;
         rd[32*k +: 32] = 32'hA5000000 + 32'h11 * k;
         rdata_q.push_back(32'hA5000000 + 32'h11 * k);
         exp_cmd_q.push_back(mk(UC_RD, 40'h0020_0000 + 40'(4 * k), 3'd2, BW'(32'hC0DE0000 + k)));
      end
      exp_resp_q.push_back(mk(UC_RD, 40'h0020_0000, 3'd6, rd));
      send(mk(UC_RD, 40'h0020_0000, 3'd6, cd));
      wait_done("t4");
      tog_rdy = 0;

      // Upstream holds off yumi: response stable, no new command accepted
      m = mk(UC_RD, 40'h0010_0004, 3'd2, BW'(32'h12345678));
      rdata_q.push_back(32'h87654321);
      exp_cmd_q.push_back(mk(UC_RD, 40'h0010_0004, 3'd2, BW'(32'h12345678)));
      exp_resp_q.push_back(mk(UC_RD, 40'h0010_0004, 3'd2, BW'(32'h87654321)));
      auto_yumi = 0;
      send(m);
      for (i = 0; i < 100; i++) begin
         @(negedge clk); #3;
         if (io_resp_v_o) break;
      end
      if (i == 100) begin
         tests++; fails++;
         $display("FAIL t5_resp_timeout: got resp_v 0 expected 1 within 100 cycles");
      end
      repeat (5) begin
         @(negedge clk); #3;
         chk("t5_resp_held", io_resp_o, mk(UC_RD, 40'h0010_0004, 3'd2, BW'(32'h87654321)));
         chk("t5_ready_low", io_cmd_ready_o, 0);
      end
      auto_yumi = 1;
      wait_done("t5");
      @(negedge clk);
      stray = 1;
      repeat (3) begin
         @(negedge clk); #3;
         chk("t5_stray_no_yumi", io_resp_yumi_o, 0);
      end
      @(negedge clk);
      stray = 0;

      // Reset after the first of two beats
      resp_en = 0;
      rdy_limit = beats_seen + 1;
      exp_cmd_q.push_back(mk(UC_RD, 40'h0010_0010, 3'd2, BW'(32'h05060708)));
      send(mk(UC_RD, 40'h0010_0010, 3'd3, BW'(64'h0102030405060708)));
      for (i = 0; i < 100; i++) begin
         if (beats_seen >= rdy_limit) break;
         @(negedge clk); #4;
      end
      if (i == 100) begin
         tests++; fails++;
         $display("FAIL t6_beat_timeout: got %0d beats expected %0d", beats_seen, rdy_limit);
      end
      @(negedge clk);
      reset_i = 1;
      repeat (2) begin
         #3;
         chk("t6_rst_cmd_ready", io_cmd_ready_o, 0);
         chk("t6_rst_cmd_v", io_cmd_v_o, 0);
         chk("t6_rst_resp_v", io_resp_v_o, 0);
         chk("t6_rst_resp_yumi", io_resp_yumi_o, 0);
         @(negedge clk);
      end
      inflight = 0;
      rdata_q.delete();
      reset_i = 0;
      resp_en = 1;
      rdy_limit = 1 << 30;
      #3;
      chk("t6_ready_after_rst", io_cmd_ready_o, 1);
      chk("t6_no_beat_after_rst", io_cmd_v_o, 0);
      rdata_q.push_back(32'hCAFEF00D);
      exp_cmd_q.push_back(mk(UC_RD, 40'h0010_0020, 3'd2, '0));
      exp_resp_q.push_back(mk(UC_RD, 40'h0010_0020, 3'd2, BW'(32'hCAFEF00D)));
      send(mk(UC_RD, 40'h0010_0020, 3'd2, '0));
      wait_done("t6");

      repeat (3) @(negedge clk);
      #4;
      chk("end_queues_empty", MW'(exp_cmd_q.size() + exp_resp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
